rr_arbiter8: RTL and testbench

- Sequential round-robin arbiter: the encoding counterpart of the one-hot decoders in the shared library.
- Takes up to NREQ request lines and grants exactly one requester.
- Presents the grant both one-hot and as a binary index. The index drives the select of a library mux4/mux8/mux16 in front of a shared resource (bus, register write port, memory).
- Holds the grant until the owner releases it, or until an optional watchdog revokes it.

---
 rtl/rr_arbiter8_pkg.sv | 17 +
 rtl/rr_arbiter8_pick.sv | 30 +++
 rtl/rr_arbiter8.sv | 90 +++++++++
 tb/tb_rr_arbiter8.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the round-robin arbiter family: FSM state encoding
// and an elaboration-time log2 helper.
package rr_arbiter8_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Round-robin winner select: rotate req so ptr is at bit 0, take the lowest
// set bit, then add ptr back to recover the absolute index.
module rr_pick #(
  parameter int NREQ = 8,
  parameter int IDXW = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   first;

  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    found = |rot;
    first = '0;
    // Descending scan so the lowest set bit is the one that sticks.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) first = IDXW'(i);
    end
    // NREQ is a power of two, so the IDXW-bit add wraps modulo NREQ.
    idx = first + ptr;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter with registered one-hot and binary grant, hold until
// release (done or request drop), and an optional watchdog.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate among req starting at ptr
// ST_GRANT | grant held; wait for done, req drop or watchdog expiry
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int NREQ    = 8,
  parameter int IDXW    = 3,
  parameter int TIMEOUT = 0,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  if (IDXW != clog2(NREQ)) begin : g_bad_idxw
    $error("rr_arbiter8: IDXW must equal clog2(NREQ)");
  end

  localparam logic [CNTW-1:0] TO_LAST = CNTW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE     = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [CNTW-1:0] cnt;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant       <= ONE << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            ptr         <= pick_idx + 1'b1;
            cnt         <= '0;
            state       <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Owner-initiated release wins over the watchdog on the same edge.
          if (done || !req[grant_idx]) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            state       <= ST_IDLE;
          end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b1;
            state       <= ST_IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: one instance without watchdog, one with
// TIMEOUT=4; expected values are hand-computed per scenario.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req, req2;
  logic       done, done2;
  logic [7:0] grant, grant2;
  logic [2:0] idx, idx2;
  logic       valid, valid2;
  logic       to, to2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.NREQ(8), .IDXW(3), .TIMEOUT(0), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(idx), .grant_valid(valid), .timeout(to)
  );

  rr_arbiter8 #(.NREQ(8), .IDXW(3), .TIMEOUT(4), .CNTW(16)) dut_wd (
    .clk(clk), .rst(rst), .req(req2), .done(done2),
    .grant(grant2), .grant_idx(idx2), .grant_valid(valid2), .timeout(to2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; req2 = '0; done = 1'b0; done2 = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      nvec++;
      if ({grant, idx, valid, to} !== 13'h0) begin
        nerr++;
        $display("FAIL reset_idle cyc%0d: got grant=%h idx=%0d valid=%b to=%b, want all 0",
                 c, grant, idx, valid, to);
      end
    end
  endtask

  task automatic test_two_req();
    logic [2:0] exp_idx [4] = '{3'd2, 3'd5, 3'd2, 3'd5};
    logic [7:0] exp_g;
    do_reset();
    req = 8'h24;
    for (int k = 0; k < 4; k++) begin
      exp_g = 8'h01 << exp_idx[k];
      for (int h = 0; h < 3; h++) begin
        step();
        nvec++;
        if (valid !== 1'b1 || grant !== exp_g || idx !== exp_idx[k]) begin
          nerr++;
          $display("FAIL two_req grant%0d hold%0d: got valid=%b grant=%h idx=%0d, want 1 %h %0d",
                   k, h, valid, grant, idx, exp_g, exp_idx[k]);
        end
      end
      done = 1'b1;
      step();
      done = 1'b0;
      nvec++;
      if (valid !== 1'b0 || grant !== 8'h00 || idx !== exp_idx[k]) begin
        nerr++;
        $display("FAIL two_req release%0d: got valid=%b grant=%h idx=%0d, want 0 00 %0d",
                 k, valid, grant, idx, exp_idx[k]);
      end
    end
  endtask

  task automatic test_all_req();
    logic [2:0] e;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      e = 3'(k % 8);
      step();
      nvec++;
      if (valid !== 1'b1 || idx !== e || grant !== (8'h01 << e)) begin
        nerr++;
        $display("FAIL all_req grant%0d: got valid=%b idx=%0d grant=%h, want 1 %0d %h",
                 k, valid, idx, grant, e, 8'h01 << e);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      nvec++;
      if (valid !== 1'b0 || grant !== 8'h00) begin
        nerr++;
        $display("FAIL all_req release%0d: got valid=%b grant=%h, want 0 00", k, valid, grant);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 8'h08;
    step();
    nvec++;
    if (valid !== 1'b1 || idx !== 3'd3 || grant !== 8'h08) begin
      nerr++;
      $display("FAIL drop_grant: got valid=%b idx=%0d grant=%h, want 1 3 08", valid, idx, grant);
    end
    req = 8'h10;
    step();
    nvec++;
    if (valid !== 1'b0 || grant !== 8'h00 || idx !== 3'd3) begin
      nerr++;
      $display("FAIL drop_release: got valid=%b grant=%h idx=%0d, want 0 00 3", valid, grant, idx);
    end
    step();
    nvec++;
    if (valid !== 1'b1 || idx !== 3'd4 || grant !== 8'h10) begin
      nerr++;
      $display("FAIL drop_regrant: got valid=%b idx=%0d grant=%h, want 1 4 10", valid, idx, grant);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req2 = 8'h01;
    for (int h = 0; h < 4; h++) begin
      step();
      nvec++;
      if (valid2 !== 1'b1 || to2 !== 1'b0 || grant2 !== 8'h01) begin
        nerr++;
        $display("FAIL wd_hold%0d: got valid=%b to=%b grant=%h, want 1 0 01", h, valid2, to2, grant2);
      end
    end
    step();
    nvec++;
    if (valid2 !== 1'b0 || to2 !== 1'b1 || grant2 !== 8'h00) begin
      nerr++;
      $display("FAIL wd_expire: got valid=%b to=%b grant=%h, want 0 1 00", valid2, to2, grant2);
    end
    step();
    nvec++;
    if (valid2 !== 1'b1 || to2 !== 1'b0 || idx2 !== 3'd0) begin
      nerr++;
      $display("FAIL wd_regrant: got valid=%b to=%b idx=%0d, want 1 0 0", valid2, to2, idx2);
    end
    // Regrant is cycle 1; advance to cycle 4, then release with done on the expiry edge.
    step();
    step();
    step();
    nvec++;
    if (valid2 !== 1'b1 || to2 !== 1'b0) begin
      nerr++;
      $display("FAIL wd_hold4: got valid=%b to=%b, want 1 0", valid2, to2);
    end
    done2 = 1'b1;
    step();
    done2 = 1'b0;
    nvec++;
    if (valid2 !== 1'b0 || to2 !== 1'b0) begin
      nerr++;
      $display("FAIL wd_done_wins: got valid=%b to=%b, want 0 0", valid2, to2);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h40;
    step();
    nvec++;
    if (valid !== 1'b1 || idx !== 3'd6) begin
      nerr++;
      $display("FAIL rstmid_grant: got valid=%b idx=%0d, want 1 6", valid, idx);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++;
    if ({grant, idx, valid, to} !== 13'h0) begin
      nerr++;
      $display("FAIL rstmid_clear: got grant=%h idx=%0d valid=%b to=%b, want all 0",
               grant, idx, valid, to);
    end
    req = 8'hC0;
    step();
    nvec++;
    if (valid !== 1'b1 || idx !== 3'd6 || grant !== 8'h40) begin
      nerr++;
      $display("FAIL rstmid_ptr: got valid=%b idx=%0d grant=%h, want 1 6 40", valid, idx, grant);
    end
  endtask

  initial begin
    test_reset();
    test_two_req();
    test_all_req();
    test_req_drop();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
